cache_nway_bank: RTL and testbench

CACHE_NWAY_BANK -- requirements
Module: cache_nway_bank

---
 rtl/cache_nway_bank.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_nway_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway_bank.sv
// N-way set-associative write-back cache bank: tree-PLRU replacement, line writeback and refill FSM.
// Optional hit/miss counters (stat_hit/stat_miss) are built in when CACHE_STATS_EN is defined.
module cache_nway_bank #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = 4,
    parameter int WAY_NUM    = 4,
    parameter int CAPACITY   = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   addr_cpu,
    input  logic [DATA_WIDTH-1:0]   wdata_cpu,
    input  logic [DATA_WIDTH/8-1:0] wmask_cpu,
    input  logic                    wen_cpu,
    input  logic                    ren_cpu,
    output logic [DATA_WIDTH-1:0]   rdata_cpu,
    output logic                    hit_cpu,
    output logic                    stall_cpu,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]             stat_hit,
    output logic [31:0]             stat_miss
`endif
);

    localparam int BYTE_NUM = DATA_WIDTH / 8;
    localparam int LINE_NUM = CAPACITY / (WAY_NUM * BANK_NUM * BYTE_NUM);
    localparam int BYTE_W   = $clog2(BYTE_NUM);
    localparam int OFF_W    = $clog2(BANK_NUM);
    localparam int IDX_W    = $clog2(LINE_NUM);
    localparam int WAY_W    = $clog2(WAY_NUM);
    localparam int TAG_W    = ADDR_WIDTH - IDX_W - OFF_W - BYTE_W;
    localparam int TAG_LSB  = BYTE_W + OFF_W + IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BANK_NUM - 1);

    typedef enum logic [2:0] {IDLE, WB, RDREQ, REFILL, DONE} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] data_mem  [LINE_NUM][WAY_NUM][BANK_NUM];
    logic [TAG_W-1:0]      tag_mem   [LINE_NUM][WAY_NUM];
    logic [WAY_NUM-1:0]    valid_mem [LINE_NUM];
    logic [WAY_NUM-1:0]    dirty_mem [LINE_NUM];
    logic [WAY_NUM-2:0]    plru_mem  [LINE_NUM];

    logic [OFF_W-1:0] cpu_word;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             req, tag_hit, inv_found, miss_go;
    logic [WAY_W-1:0] hit_way, inv_way, victim_way;

    logic [WAY_W-1:0] vic_way_q;
    logic [IDX_W-1:0] vic_idx_q;
    logic [TAG_W-1:0] vic_tag_q, miss_tag_q;
    logic [OFF_W-1:0] beat_q;
    logic             unused_bits;

    // Tree bits point toward the less-recently-used half (0 = lower-index side).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAY_NUM-2:0] bits);
        int unsigned      node;
        logic [WAY_W-1:0] way;
        node = 0;
        way  = '0;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            way[WAY_W-1-l] = bits[node];
            node = 2 * node + (bits[node] ? 2 : 1);
        end
        return way;
    endfunction

    function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] bits,
                                                      input logic [WAY_W-1:0]   way);
        int unsigned        node;
        logic [WAY_NUM-2:0] res;
        node = 0;
        res  = bits;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            res[node] = ~way[WAY_W-1-l];
            node = 2 * node + (way[WAY_W-1-l] ? 2 : 1);
        end
        return res;
    endfunction

    assign cpu_word    = addr_cpu[BYTE_W +: OFF_W];
    assign cpu_idx     = addr_cpu[BYTE_W+OFF_W +: IDX_W];
    assign cpu_tag     = addr_cpu[TAG_LSB +: TAG_W];
    assign unused_bits = ^addr_cpu[BYTE_W-1:0];
    assign req         = ren_cpu | wen_cpu;

    always_comb begin
        tag_hit   = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAY_NUM; w++) begin
            if (valid_mem[cpu_idx][w] && tag_mem[cpu_idx][w] == cpu_tag && !tag_hit) begin
                tag_hit = 1'b1;
                hit_way = w[WAY_W-1:0];
            end
            if (!valid_mem[cpu_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = w[WAY_W-1:0];
            end
        end
        victim_way = inv_found ? inv_way : plru_victim(plru_mem[cpu_idx]);
    end

    assign hit_cpu   = req & (state == IDLE) & tag_hit;
    assign stall_cpu = req & ~hit_cpu;
    assign rdata_cpu = data_mem[cpu_idx][hit_way][cpu_word];
    assign miss_go   = req & (state == IDLE) & ~tag_hit;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (miss_go)
                         state_nxt = (valid_mem[cpu_idx][victim_way] && dirty_mem[cpu_idx][victim_way])
                                     ? WB : RDREQ;
            WB:      if (mem_req_ready && beat_q == LAST_BEAT) state_nxt = RDREQ;
            RDREQ:   if (mem_req_ready) state_nxt = REFILL;
            REFILL:  if (mem_rvalid && beat_q == LAST_BEAT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state)
            WB: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                mem_addr      = {vic_tag_q, vic_idx_q, beat_q, {BYTE_W{1'b0}}};
                mem_wdata     = data_mem[vic_idx_q][vic_way_q][beat_q];
            end
            RDREQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = {miss_tag_q, vic_idx_q, {OFF_W{1'b0}}, {BYTE_W{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_q <= '0;
        end else begin
            case (state)
                WB:      if (mem_req_ready) beat_q <= beat_q + 1'b1;
                REFILL:  if (mem_rvalid)    beat_q <= beat_q + 1'b1;
                default: beat_q <= '0;
            endcase
        end
    end

    // The old tag is captured before the victim is retagged so writeback addresses stay correct.
    always_ff @(posedge clk) begin
        if (miss_go) begin
            vic_way_q  <= victim_way;
            vic_idx_q  <= cpu_idx;
            vic_tag_q  <= tag_mem[cpu_idx][victim_way];
            miss_tag_q <= cpu_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            if (hit_cpu && wen_cpu) begin
                for (int unsigned b = 0; b < BYTE_NUM; b++)
                    if (wmask_cpu[b])
                        data_mem[cpu_idx][hit_way][cpu_word][8*b +: 8] <= wdata_cpu[8*b +: 8];
            end
            if (miss_go)
                tag_mem[cpu_idx][victim_way] <= cpu_tag;
            if (state == REFILL && mem_rvalid)
                data_mem[vic_idx_q][vic_way_q][beat_q] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < LINE_NUM; i++) begin
                valid_mem[i] <= '0;
                dirty_mem[i] <= '0;
                plru_mem[i]  <= '0;
            end
        end else begin
            if (hit_cpu) begin
                plru_mem[cpu_idx] <= plru_touch(plru_mem[cpu_idx], hit_way);
                if (wen_cpu) dirty_mem[cpu_idx][hit_way] <= 1'b1;
            end
            if (miss_go)
                valid_mem[cpu_idx][victim_way] <= 1'b0;
            if (state == DONE) begin
                valid_mem[vic_idx_q][vic_way_q] <= 1'b1;
                dirty_mem[vic_idx_q][vic_way_q] <= 1'b0;
                plru_mem[vic_idx_q]             <= plru_touch(plru_mem[vic_idx_q], vic_way_q);
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_hit  <= '0;
            stat_miss <= '0;
        end else begin
            if (hit_cpu) stat_hit  <= stat_hit + 32'd1;
            if (miss_go) stat_miss <= stat_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_nway_bank.sv
// Directed bench for cache_nway_bank: hit/store vector table plus refill, writeback, stalled-writeback and reset-abort sequences.
// Stat counters are checked only when CACHE_STATS_EN is defined.
module tb_cache_nway_bank;

    typedef logic [3:0][63:0] line_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        exp_hit;
        logic        exp_stall;
        logic        chk_rd;
        logic [63:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] addr_cpu, wdata_cpu, rdata_cpu;
    logic [7:0]  wmask_cpu;
    logic        wen_cpu, ren_cpu, hit_cpu, stall_cpu;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hit, stat_miss;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_nway_bank #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .BANK_NUM(4), .WAY_NUM(4), .CAPACITY(4096)
    ) dut (
        .clk(clk), .rstn(rstn),
        .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu),
        .wen_cpu(wen_cpu), .ren_cpu(ren_cpu),
        .rdata_cpu(rdata_cpu), .hit_cpu(hit_cpu), .stall_cpu(stall_cpu),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .stat_hit(stat_hit), .stat_miss(stat_miss)
`endif
    );

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", what, act, exp);
        end
    endtask

    function automatic line_t mk_line(input logic [63:0] base);
        return {base + 64'd3, base + 64'd2, base + 64'd1, base};
    endfunction

    // Entered just after a rising edge; leaves just after a rising edge with the request dropped.
    task automatic apply_vec(input string name, input vec_t v);
        wen_cpu   = v.wr;
        ren_cpu   = v.rd;
        addr_cpu  = v.addr;
        wdata_cpu = v.wdata;
        wmask_cpu = v.wmask;
        @(negedge clk);
        check({name, " hit"}, hit_cpu, v.exp_hit);
        check({name, " stall"}, stall_cpu, v.exp_stall);
        if (v.chk_rd) check({name, " rdata"}, rdata_cpu, v.exp_rd);
        @(posedge clk); #1;
        wen_cpu = 1'b0;
        ren_cpu = 1'b0;
    endtask

    // Full miss: optional writeback (with wb_hold cycles of mem_req_ready low), read request, refill, retry hit.
    task automatic miss_access(input string name, input logic wr, input logic [63:0] a,
                               input logic [63:0] wd, input logic [7:0] wm,
                               input logic exp_wb, input logic [63:0] wb_base, input line_t wb_line,
                               input line_t fill, input int wb_hold);
        int  wb_beats, held, fill_beat, stalls;
        logic rd_seen, done;
        logic [63:0] line_addr;
        line_addr = {a[63:5], 5'b0};
        wb_beats = 0; held = 0; fill_beat = 0; stalls = 0;
        rd_seen = 1'b0; done = 1'b0;
        wen_cpu = wr; ren_cpu = ~wr; addr_cpu = a; wdata_cpu = wd; wmask_cpu = wm;
        mem_req_ready = (wb_hold == 0);
        @(negedge clk);
        check({name, " miss hit"}, hit_cpu, 1'b0);
        check({name, " miss stall"}, stall_cpu, 1'b1);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk); #1;
            if (rd_seen && fill_beat < 4) begin
                mem_rvalid = 1'b1;
                mem_rdata  = fill[fill_beat];
                fill_beat++;
            end else begin
                mem_rvalid = 1'b0;
            end
            if (held == wb_hold) mem_req_ready = 1'b1;
            @(negedge clk);
            if (hit_cpu) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (rd_seen) begin
                    check({name, " req low after rdreq"}, mem_req_valid, 1'b0);
                end else if (mem_req_valid && mem_we) begin
                    if (wb_beats < 4) begin
                        check({name, " wb addr"}, mem_addr, wb_base + 64'(wb_beats * 8));
                        check({name, " wb data"}, mem_wdata, wb_line[wb_beats]);
                    end
                    if (mem_req_ready) wb_beats++;
                    else               held++;
                end else if (mem_req_valid) begin
                    check({name, " rdreq addr"}, mem_addr, line_addr);
                    check({name, " wb beats before rdreq"}, wb_beats, exp_wb ? 4 : 0);
                    rd_seen = 1'b1;
                end
            end
        end
        check({name, " retry hit reached"}, done, 1'b1);
        check({name, " stall cycles"}, stalls, (exp_wb ? 4 : 0) + wb_hold + 6);
        check({name, " req idle at hit"}, mem_req_valid, 1'b0);
        if (!wr) check({name, " retry rdata"}, rdata_cpu, fill[a[4:3]]);
        @(posedge clk); #1;
        wen_cpu = 1'b0; ren_cpu = 1'b0; mem_rvalid = 1'b0; mem_req_ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t  vecs [9];
        line_t wb_a, wb_b, none;
        logic  got;

        vecs[0] = '{1'b0, 1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b0, 64'h1008, 64'hFFFF_FFFF, 8'h0F, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[2] = '{1'b0, 1'b1, 64'h1008, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF};
        vecs[3] = '{1'b0, 1'b1, 64'h1000, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'hA0};
        vecs[4] = '{1'b0, 1'b1, 64'h1018, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'hA3};
        vecs[5] = '{1'b1, 1'b0, 64'h1010, 64'h1234_5678_0000_0000, 8'hF0, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[6] = '{1'b0, 1'b1, 64'h1010, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h1234_5678_0000_00A2};
        vecs[7] = '{1'b0, 1'b1, 64'h1014, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h1234_5678_0000_00A2};
        vecs[8] = '{1'b0, 1'b0, 64'h2000, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0, 64'h0};

        wb_a = {64'hA3, 64'h1234_5678_0000_00A2, 64'h0000_0000_FFFF_FFFF, 64'hA0};
        wb_b = {64'h1403, 64'h1402, 64'h1401, 64'hDEAD_BEEF_0000_5555};
        none = '0;

        rstn = 1'b0; addr_cpu = '0; wdata_cpu = '0; wmask_cpu = '0;
        wen_cpu = 1'b0; ren_cpu = 1'b0; mem_req_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset req_valid", mem_req_valid, 1'b0);
        check("reset stall", stall_cpu, 1'b0);
        check("reset hit", hit_cpu, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post-reset req_valid", mem_req_valid, 1'b0);
`ifdef CACHE_STATS_EN
        check("reset stat_hit", stat_hit, 32'd0);
        check("reset stat_miss", stat_miss, 32'd0);
`endif
        @(posedge clk); #1;

        miss_access("fill 1000", 1'b0, 64'h1000, 64'h0, 8'h00, 1'b0, 64'h0, none,
                    {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 0);

        for (int i = 0; i < 9; i++)
            apply_vec($sformatf("vec%0d", i), vecs[i]);

        miss_access("fill 2000", 1'b0, 64'h2000, 64'h0, 8'h00, 1'b0, 64'h0, none, mk_line(64'h800), 0);
        miss_access("fill 3000", 1'b0, 64'h3000, 64'h0, 8'h00, 1'b0, 64'h0, none, mk_line(64'hC00), 0);
        miss_access("fill 4000", 1'b0, 64'h4000, 64'h0, 8'h00, 1'b0, 64'h0, none, mk_line(64'h1000), 0);

        // All four ways valid; PLRU points at way 0 (dirty line 0x1000).
        miss_access("evict 1000", 1'b0, 64'h5000, 64'h0, 8'h00, 1'b1, 64'h1000, wb_a,
                    mk_line(64'h1400), 0);

        apply_vec("store 5000", vec_t'{1'b1, 1'b0, 64'h5000, 64'hDEAD_BEEF_0000_5555, 8'hFF,
                                       1'b1, 1'b0, 1'b0, 64'h0});
        apply_vec("load 2000", vec_t'{1'b0, 1'b1, 64'h2000, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h800});
        apply_vec("load 3000", vec_t'{1'b0, 1'b1, 64'h3000, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'hC00});

        miss_access("evict 5000 held", 1'b0, 64'h6000, 64'h0, 8'h00, 1'b1, 64'h5000, wb_b,
                    mk_line(64'h1800), 10);

        // Reset during refill beat 2 must leave the line invalid.
        ren_cpu = 1'b1; addr_cpu = 64'h1020; mem_req_ready = 1'b1;
        @(negedge clk);
        check("abort miss stall", stall_cpu, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (mem_req_valid && !mem_we) got = 1'b1;
        end
        check("abort rdreq seen", got, 1'b1);
        check("abort rdreq addr", mem_addr, 64'h1020);
        @(posedge clk); #1; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0;
        @(posedge clk); #1; mem_rdata = 64'hBAD1;
        @(posedge clk); #1; mem_rdata = 64'hBAD2; rstn = 1'b0;
        @(posedge clk); #1; rstn = 1'b1; mem_rvalid = 1'b0; ren_cpu = 1'b0;
        @(negedge clk);
        check("abort req_valid", mem_req_valid, 1'b0);
        check("abort stall", stall_cpu, 1'b0);
        @(posedge clk); #1;

        miss_access("refetch 1020", 1'b0, 64'h1020, 64'h0, 8'h00, 1'b0, 64'h0, none, mk_line(64'h2200), 0);
        apply_vec("hit 1020", vec_t'{1'b0, 1'b1, 64'h1020, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h2200});
        apply_vec("hit 1028", vec_t'{1'b0, 1'b1, 64'h1028, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h2201});
        apply_vec("hit 1038", vec_t'{1'b0, 1'b1, 64'h1038, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1, 64'h2203});
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stat_hit", stat_hit, 32'd4);
        check("stat_miss", stat_miss, 32'd1);
        @(posedge clk); #1;
`endif

        miss_access("refetch 6000", 1'b0, 64'h6000, 64'h0, 8'h00, 1'b0, 64'h0, none, mk_line(64'h3300), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
